// File: rtl/arb2_path_sequencer.sv
// arb2_path_sequencer: two-requester round-robin arbiter/sequencer driving the
// 2:1 select of a shared WIDTH-bit datapath. Grants last until the owner drops
// its request, sends a final beat, or uses MAX_HOLD beats while the other side
// waits. Optional per-side beat counters are built when ARB2_STATS_EN is
// defined. Arbitration does not depend on that macro.
module arb2_path_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             last_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic             last_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             out_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
`ifdef ARB2_STATS_EN
  ,
  output logic [15:0]      beats_a,
  output logic [15:0]      beats_b
`endif
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            ptr_q, ptr_d;      // 0 = A has priority, 1 = B
  logic [CW-1:0]   cnt_q, cnt_d;

  // Owner-relative view of the inputs, so one release rule serves both sides.
  logic            own_req;
  logic            own_last;
  logic            oth_req;
  logic            beat;
  logic [CW-1:0]   cnt_inc;
  logic            hit_max;
  logic            release_now;

  // Select the current owner's request/last and the waiting side's request.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    oth_req  = 1'b0;
    case (state_q)
      OWN_A: begin
        own_req  = req_a;
        own_last = last_a;
        oth_req  = req_b;
      end
      OWN_B: begin
        own_req  = req_b;
        own_last = last_b;
        oth_req  = req_a;
      end
      default: begin
        own_req  = 1'b0;
        own_last = 1'b0;
        oth_req  = 1'b0;
      end
    endcase
  end

  assign beat        = own_req & out_ready;
  assign cnt_inc     = cnt_q + CW'(1);
  assign hit_max     = (cnt_inc == CW'(MAX_HOLD));
  assign release_now = !own_req || (beat && own_last) || (beat && hit_max && oth_req);

  // Next-state: arbitration from IDLE, release/handoff from the owning states.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !ptr_q)) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (release_now) begin
          // Hand straight to a waiting other side; no idle bubble.
          if (oth_req) begin
            state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
          end else begin
            state_d = IDLE;
          end
          ptr_d = (state_q == OWN_A);
          cnt_d = '0;
        end else if (beat) begin
          // Reaching MAX_HOLD with nobody waiting wraps and keeps the grant.
          cnt_d = hit_max ? '0 : cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Select follows the granted side and keeps its last value while idle.
    if (state_d == OWN_B) begin
      sel_d = 1'b1;
    end else if (state_d == OWN_A) begin
      sel_d = 1'b0;
    end
  end

  // State, select, priority pointer and hold count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_a     = (state_q == OWN_A);
  assign gnt_b     = (state_q == OWN_B);
  assign sel       = sel_q;
  assign out_data  = sel_q ? data_b : data_a;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);

`ifdef ARB2_STATS_EN
  logic [15:0] beats_a_q;
  logic [15:0] beats_b_q;
  logic        beat_a;
  logic        beat_b;

  assign beat_a = gnt_a & req_a & out_ready;
  assign beat_b = gnt_b & req_b & out_ready;

  // Saturating completed-beat counters per side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_a_q <= '0;
      beats_b_q <= '0;
    end else begin
      if (beat_a && (beats_a_q != '1)) beats_a_q <= beats_a_q + 16'd1;
      if (beat_b && (beats_b_q != '1)) beats_b_q <= beats_b_q + 16'd1;
    end
  end

  assign beats_a = beats_a_q;
  assign beats_b = beats_b_q;
`endif

endmodule

// File: tb/tb_arb2_path_sequencer.sv
// Directed bench for arb2_path_sequencer: a vector table for short handshake
// sequences plus hand-written sequences for reset, hold limit and hold wrap.
// Builds with or without ARB2_STATS_EN.
module tb_arb2_path_sequencer;

  localparam logic [31:0] DA = 32'hDEADBEEF;
  localparam logic [31:0] DB = 32'hCAFEF00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, last_a, req_b, last_b, out_ready;
  logic [31:0] data_a, data_b;
  logic        gnt_a, gnt_b, sel, out_valid;
  logic [31:0] out_data;
`ifdef ARB2_STATS_EN
  logic [15:0] beats_a, beats_b;
`endif

  int checks = 0;
  int errors = 0;

  arb2_path_sequencer #(.WIDTH(32), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .last_a(last_a), .data_a(data_a),
    .req_b(req_b), .last_b(last_b), .data_b(data_b),
    .out_ready(out_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_data(out_data), .out_valid(out_valid)
`ifdef ARB2_STATS_EN
    , .beats_a(beats_a), .beats_b(beats_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;   // rst_n value during this vector
    logic ra, la, rb, lb, rdy;
    logic ga, gb, sl, ov;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1.
  task automatic step(input string name, input logic rst, input logic ra, input logic la,
                      input logic rb, input logic lb, input logic rdy,
                      input logic ga, input logic gb, input logic sl, input logic ov);
    rst_n = rst; req_a = ra; last_a = la; req_b = rb; last_b = lb; out_ready = rdy;
    #3;
    chk({name, ".gnt_a"}, {31'd0, gnt_a}, {31'd0, ga});
    chk({name, ".gnt_b"}, {31'd0, gnt_b}, {31'd0, gb});
    chk({name, ".sel"}, {31'd0, sel}, {31'd0, sl});
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, ".out_data"}, out_data, sl ? DB : DA);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 0; last_a = 0; req_b = 0; last_b = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    data_a = DA;
    data_b = DB;
    //               rst ra la rb lb rdy  ga gb sl ov
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
    vecs[17] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};
    vecs[18] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1};
    vecs[19] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1};
    vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};

    do_reset();
    #3;
    chk("reset.gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("reset.gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("reset.sel", {31'd0, sel}, 32'd0);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.out_data", out_data, DA);
`ifdef ARB2_STATS_EN
    chk("reset.beats_a", {16'd0, beats_a}, 32'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ra, vecs[i].la, vecs[i].rb,
           vecs[i].lb, vecs[i].rdy, vecs[i].ga, vecs[i].gb, vecs[i].sl, vecs[i].ov);
    end

    // Reset mid-burst while B owns the path.
    do_reset();
    step("mrst.idle", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("mrst.ownb", 1, 0, 0, 1, 0, 1, 0, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("mrst.sel", {31'd0, sel}, 32'd0);
    chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    req_b = 0;
    rst_n = 1'b1;
    step("mrst.reqa", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("mrst.gnta", 1, 1, 0, 0, 0, 1, 1, 0, 0, 1);

    // Hold limit: exactly 8 A beats while B waits, then B with last on beat 2.
    do_reset();
    step("hold.idle", 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step($sformatf("hold.a%0d", i), 1, 1, 0, 1, 0, 1, 1, 0, 0, 1);
    step("hold.b0", 1, 1, 0, 1, 0, 1, 0, 1, 1, 1);
    step("hold.b1", 1, 1, 0, 1, 1, 1, 0, 1, 1, 1);
    rst_n = 1; req_a = 1; last_a = 0; req_b = 1; last_b = 0; out_ready = 0;
    #3;
    chk("hold.back_a", {31'd0, gnt_a}, 32'd1);
`ifdef ARB2_STATS_EN
    chk("hold.beats_a", {16'd0, beats_a}, 32'd8);
    chk("hold.beats_b", {16'd0, beats_b}, 32'd2);
`endif
    @(posedge clk); #1;

    // Hold wrap: 20 A beats alone, then 4 more reach the limit once B waits.
    do_reset();
    step("wrap.idle", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step($sformatf("wrap.a%0d", i), 1, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    step("wrap.stall", 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
`ifdef ARB2_STATS_EN
    chk("wrap.beats_a", {16'd0, beats_a}, 32'd20);
`endif
    for (int i = 0; i < 4; i++) step($sformatf("wrap.c%0d", i), 1, 1, 0, 1, 0, 1, 1, 0, 0, 1);
    step("wrap.tob", 1, 1, 0, 1, 0, 0, 0, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb2_path_sequencer.md
Name: arb2_path_sequencer

Overview:
- Two-requester arbiter and sequencer for a shared 32-bit datapath built around a 2:1 select; e.g. two masters (fetch path, load/store path) sharing one memory/result bus.
- Runs request/grant handshakes with round-robin fairness and a burst hold limit.
- Drives the select line, steers the winning requester's data onto the shared output, and qualifies each beat against downstream ready.

Parameters:
- WIDTH, 32, datapath width.
- MAX_HOLD, 8, max beats per grant when the other side is waiting (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A wants the path; held high while it has data.
- last_a  input  1  qualifies A's current beat as final of burst.
- data_a  input  WIDTH  A's data.
- req_b  input  1  requester B request.
- last_b  input  1  B final-beat flag.
- data_b  input  WIDTH  B's data.
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt_a  output  1  A owns the path (registered).
- gnt_b  output  1  B owns the path (registered).
- sel  output  1  path select, 0=A, 1=B (registered).
- out_data  output  WIDTH  sel ? data_b : data_a (combinational from registered sel).
- out_valid  output  1  (gnt_a&req_a)|(gnt_b&req_b).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; gnt_a=gnt_b=0; sel=0; priority pointer=A; hold count=0.
  - out_valid=0. out_data=data_a.
  - Takes effect immediately mid-burst; an in-flight beat is dropped.
- States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B). sel is 1 only in OWN_B and holds its last value in IDLE.
- Beat definition: in OWN_X, a beat occurs when req_X & out_ready are both high on a rising edge.
- IDLE transitions:
  - Only req_a -> OWN_A.
  - Only req_b -> OWN_B.
  - Both -> side named by the pointer.
  - Neither -> stay.
  - Grant appears one cycle after req is seen (1-cycle latency).
- Release conditions in OWN_X:
  - (a) req_X low;
  - (b) beat with last_X=1;
  - (c) beat that brings hold count to MAX_HOLD while req_Y (other side) is high.
- On release:
  - If req_Y is high, go directly to OWN_Y with no idle bubble; otherwise go to IDLE.
  - Pointer always set to Y. Hold count cleared.
- Hold count:
  - Increments on each beat in OWN_X; width $clog2(MAX_HOLD+1).
  - At MAX_HOLD with req_Y low: wraps to 0 and grant is kept.
  - Cleared on every grant change.
- Simultaneous events:
  - req_X drop together with req_Y rise: handoff to Y next cycle.
  - out_ready low: no beat, count frozen, grant held, unless req_X drops.
- last_X without a beat (out_ready=0) is ignored.
- out_valid may be high while out_ready is low; the requester must hold data_X stable until the beat completes.
- No combinational path from out_ready to gnt/sel; only out_valid/out_data are combinational.

Optional Feature:
- Macro: ARB2_STATS_EN.
- Defined:
  - Adds outputs beats_a[15:0] and beats_b[15:0].
  - Each counts completed beats for its side and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: ports and counters absent. Arbitration is identical either way.

Test Plan:
- Reset mid-burst: OWN_B with sel=1, pull rst_n low between edges -> gnt_b, sel, out_valid fall to 0 immediately. After release, req_a alone -> gnt_a=1 one cycle later.
- Single requester: req_a=1, out_ready=1, data_a=32'hDEADBEEF, last_a on 3rd beat -> out_data=32'hDEADBEEF with out_valid=1 for 3 beats, then IDLE, gnt_a=0.
- Simultaneous first requests after reset: req_a=req_b=1 -> OWN_A first. A releases via last -> gnt_b=1 on the next cycle, no idle.
- Hold limit: MAX_HOLD=8, A streams without last, req_b=1 throughout -> exactly 8 A beats, then sel=1. B with last on beat 2 -> back to A.
- Backpressure: in OWN_A, out_ready=0 for 5 cycles -> count unchanged, gnt_a held, no beats (beats_a unchanged with ARB2_STATS_EN). last_a asserted while out_ready=0 is ignored.
- Hold wrap: MAX_HOLD=8, req_b=0, A sends 20 beats -> grant never drops, count wraps at 8. beats_a=20 with ARB2_STATS_EN.
